// File: rtl/tick_monitor.sv
// tick_monitor: checks a periodic one-cycle tick strobe against a nominal
// period. It measures the clk-cycle spacing of tick rising edges, flags each
// interval as early or late, and raises a lock flag after a run of good intervals.
module tick_monitor #(
    parameter int unsigned COUNT_WIDTH = 32,
    parameter int unsigned EXPECT      = 12000000,
    parameter int unsigned TOL         = 1000,
    parameter int unsigned LOCK_COUNT  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   tick,
    output logic [COUNT_WIDTH-1:0] period,
    output logic                   period_valid,
    output logic                   early,
    output logic                   late,
    output logic                   locked
);

    // Window bounds. The timeout value is one past the late bound, so the
    // counter saturates there and never wraps.
    localparam logic [COUNT_WIDTH-1:0] LO      = COUNT_WIDTH'(EXPECT - TOL);
    localparam logic [COUNT_WIDTH-1:0] HI      = COUNT_WIDTH'(EXPECT + TOL);
    localparam logic [COUNT_WIDTH-1:0] TIMEOUT = COUNT_WIDTH'(EXPECT + TOL + 1);
    localparam int unsigned            RUN_W   = $clog2(LOCK_COUNT + 1);
    localparam logic [RUN_W-1:0]       RUN_MAX = RUN_W'(LOCK_COUNT);

    // state      | meaning
    // IDLE       | disabled or just reset; counters cleared, lock dropped
    // WAIT_FIRST | armed, waiting for a reference edge to start timing
    // MEASURE    | timing the interval since the previous edge
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [RUN_W-1:0]       run_q, run_d;
    logic                   tick_prev_q, tick_prev_d;
    logic [COUNT_WIDTH-1:0] period_q, period_d;
    logic                   period_valid_q, period_valid_d;
    logic                   early_q, early_d;
    logic                   late_q, late_d;
    logic                   locked_q, locked_d;
    logic                   tick_rise;

    // Next-state and output decode; pulse outputs default low every cycle.
    always_comb begin
        tick_rise      = tick & ~tick_prev_q;
        tick_prev_d    = tick;
        state_d        = state_q;
        count_d        = count_q;
        run_d          = run_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        early_d        = 1'b0;
        late_d         = 1'b0;
        locked_d       = locked_q;

        if (!en) begin
            state_d  = IDLE;
            count_d  = '0;
            run_d    = '0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT_FIRST;
                end
                WAIT_FIRST: begin
                    if (tick_rise) begin
                        count_d = COUNT_WIDTH'(1);
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (tick_rise) begin
                        // An edge that lands exactly on the timeout count is
                        // still a measured (late) interval.
                        period_d       = count_q;
                        period_valid_d = 1'b1;
                        count_d        = COUNT_WIDTH'(1);
                        if (count_q < LO) begin
                            early_d  = 1'b1;
                            run_d    = '0;
                            locked_d = 1'b0;
                        end else if (count_q > HI) begin
                            late_d   = 1'b1;
                            run_d    = '0;
                            locked_d = 1'b0;
                        end else begin
                            if (run_q != RUN_MAX) begin
                                run_d = run_q + RUN_W'(1);
                            end
                            locked_d = (run_d == RUN_MAX);
                        end
                    end else if (count_q == TIMEOUT) begin
                        late_d   = 1'b1;
                        run_d    = '0;
                        locked_d = 1'b0;
                        count_d  = '0;
                        state_d  = WAIT_FIRST;
                    end else begin
                        count_d = count_q + COUNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            count_q        <= '0;
            run_q          <= '0;
            tick_prev_q    <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            early_q        <= 1'b0;
            late_q         <= 1'b0;
            locked_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            run_q          <= run_d;
            tick_prev_q    <= tick_prev_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            early_q        <= early_d;
            late_q         <= late_d;
            locked_q       <= locked_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign early        = early_q;
    assign late         = late_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_tick_monitor.sv
// Testbench for tick_monitor with EXPECT=10, TOL=1, LOCK_COUNT=3.
// An interval-level model pushes expected output events into a queue as tick
// edges are driven; a monitor records every pulse the DUT produces.
module tb_tick_monitor;

    localparam int CW   = 16;
    localparam int EXP  = 10;
    localparam int TOL  = 1;
    localparam int LOCK = 3;
    localparam int LO   = EXP - TOL;
    localparam int HI   = EXP + TOL;

    typedef struct packed {
        logic [CW-1:0] period;
        logic          valid;
        logic          early;
        logic          late;
        logic          locked;
    } ev_t;

    logic          clk;
    logic          rst;
    logic          en;
    logic          tick;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          early;
    logic          late;
    logic          locked;

    int n_checks = 0;
    int n_fail   = 0;

    ev_t exp_q[$];
    ev_t obs_q[$];

    // model state
    bit          m_meas   = 0;
    int          m_run    = 0;
    bit          m_locked = 0;
    logic [CW-1:0] m_period = '0;
    int          m_gap    = 0;

    tick_monitor #(
        .COUNT_WIDTH(CW),
        .EXPECT     (EXP),
        .TOL        (TOL),
        .LOCK_COUNT (LOCK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .tick        (tick),
        .period      (period),
        .period_valid(period_valid),
        .early       (early),
        .late        (late),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // record every DUT pulse, sampled away from the active edge
    always @(negedge clk) begin
        if (period_valid || early || late)
            obs_q.push_back('{period, period_valid, early, late, locked});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // a pending timeout has fired once more than HI+1 cycles passed without an edge
    task automatic model_settle();
        if (m_meas && m_gap > HI + 1) begin
            exp_q.push_back('{m_period, 1'b0, 1'b0, 1'b1, 1'b0});
            m_meas   = 0;
            m_run    = 0;
            m_locked = 0;
        end
    endtask

    task automatic model_edge();
        model_settle();
        if (!m_meas) begin
            m_meas = 1;
        end else begin
            m_period = CW'(m_gap);
            if (m_gap < LO) begin
                m_run = 0; m_locked = 0;
                exp_q.push_back('{m_period, 1'b1, 1'b1, 1'b0, 1'b0});
            end else if (m_gap > HI) begin
                m_run = 0; m_locked = 0;
                exp_q.push_back('{m_period, 1'b1, 1'b0, 1'b1, 1'b0});
            end else begin
                if (m_run < LOCK) m_run = m_run + 1;
                if (m_run == LOCK) m_locked = 1;
                exp_q.push_back('{m_period, 1'b1, 1'b0, 1'b0, m_locked});
            end
        end
        m_gap = 0;
    endtask

    // raise tick now (at a negedge), hold it 'hold' cycles, next edge 'spacing' cycles later
    task automatic drive_tick(input int spacing, input int hold);
        model_edge();
        tick = 1'b1;
        for (int i = 0; i < spacing; i++) begin
            @(negedge clk);
            if (i + 1 == hold) tick = 1'b0;
            m_gap = m_gap + 1;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            m_gap = m_gap + 1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; tick = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (period !== '0)     begin n_fail++; $display("FAIL reset period: got %0d, exp 0", period); end
        n_checks++; if (period_valid !== 0) begin n_fail++; $display("FAIL reset period_valid: got %b, exp 0", period_valid); end
        n_checks++; if (early !== 0)       begin n_fail++; $display("FAIL reset early: got %b, exp 0", early); end
        n_checks++; if (late !== 0)        begin n_fail++; $display("FAIL reset late: got %b, exp 0", late); end
        n_checks++; if (locked !== 0)      begin n_fail++; $display("FAIL reset locked: got %b, exp 0", locked); end
        @(negedge clk);
        rst = 1'b1; en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nominal_lock();
        ev_t e, o;
        for (int i = 0; i < 5; i++) drive_tick(10, 1);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL nominal event: got none, exp p=%0d v=%b e=%b l=%b lk=%b", e.period, e.valid, e.early, e.late, e.locked); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL nominal event: got p=%0d v=%b e=%b l=%b lk=%b, exp p=%0d v=%b e=%b l=%b lk=%b", o.period, o.valid, o.early, o.late, o.locked, e.period, e.valid, e.early, e.late, e.locked); end end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL nominal extra events: got %0d, exp 0", obs_q.size()); obs_q.delete(); end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL nominal locked level: got %b, exp 1", locked); end
    endtask

    task automatic test_window_edges();
        ev_t e, o;
        int gaps[6] = '{9, 11, 8, 12, 10, 10};
        foreach (gaps[i]) drive_tick(gaps[i], 1);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL window event: got none, exp p=%0d v=%b e=%b l=%b lk=%b", e.period, e.valid, e.early, e.late, e.locked); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL window event: got p=%0d v=%b e=%b l=%b lk=%b, exp p=%0d v=%b e=%b l=%b lk=%b", o.period, o.valid, o.early, o.late, o.locked, e.period, e.valid, e.early, e.late, e.locked); end end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL window extra events: got %0d, exp 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_timeout();
        ev_t e, o;
        for (int i = 0; i < 4; i++) drive_tick(10, 1);
        idle_cycles(5);
        model_settle();
        #1;
        n_checks++; if (locked !== m_locked) begin n_fail++; $display("FAIL timeout locked: got %b, exp %b", locked, m_locked); end
        @(negedge clk);
        m_gap = m_gap + 1;
        drive_tick(10, 1);
        drive_tick(10, 1);
        drive_tick(10, 1);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL timeout event: got none, exp p=%0d v=%b e=%b l=%b lk=%b", e.period, e.valid, e.early, e.late, e.locked); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL timeout event: got p=%0d v=%b e=%b l=%b lk=%b, exp p=%0d v=%b e=%b l=%b lk=%b", o.period, o.valid, o.early, o.late, o.locked, e.period, e.valid, e.early, e.late, e.locked); end end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL timeout extra events: got %0d, exp 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_stretched_tick();
        ev_t e, o;
        for (int i = 0; i < 4; i++) drive_tick(10, 4);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL stretched event: got none, exp p=%0d v=%b e=%b l=%b lk=%b", e.period, e.valid, e.early, e.late, e.locked); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL stretched event: got p=%0d v=%b e=%b l=%b lk=%b, exp p=%0d v=%b e=%b l=%b lk=%b", o.period, o.valid, o.early, o.late, o.locked, e.period, e.valid, e.early, e.late, e.locked); end end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL stretched extra events: got %0d, exp 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_enable_drop();
        ev_t e, o;
        en = 1'b0;
        repeat (2) @(negedge clk);
        en = 1'b1;
        m_meas = 0; m_run = 0; m_locked = 0;
        #1;
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL enable locked: got %b, exp 0", locked); end
        n_checks++; if (period !== m_period) begin n_fail++; $display("FAIL enable period hold: got %0d, exp %0d", period, m_period); end
        @(negedge clk);
        for (int i = 0; i < 3; i++) drive_tick(10, 1);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL enable event: got none, exp p=%0d v=%b e=%b l=%b lk=%b", e.period, e.valid, e.early, e.late, e.locked); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL enable event: got p=%0d v=%b e=%b l=%b lk=%b, exp p=%0d v=%b e=%b l=%b lk=%b", o.period, o.valid, o.early, o.late, o.locked, e.period, e.valid, e.early, e.late, e.locked); end end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL enable extra events: got %0d, exp 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_reset_mid();
        ev_t e, o;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_meas = 0; m_run = 0; m_locked = 0; m_period = '0;
        #1;
        n_checks++; if (period !== m_period) begin n_fail++; $display("FAIL midreset period: got %0d, exp %0d", period, m_period); end
        n_checks++; if ({period_valid, early, late, locked} !== 4'b0000) begin n_fail++; $display("FAIL midreset flags v/e/l/lk: got %b, exp 0000", {period_valid, early, late, locked}); end
        @(negedge clk);
        drive_tick(10, 1);
        drive_tick(10, 1);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL midreset event: got none, exp p=%0d v=%b e=%b l=%b lk=%b", e.period, e.valid, e.early, e.late, e.locked); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL midreset event: got p=%0d v=%b e=%b l=%b lk=%b, exp p=%0d v=%b e=%b l=%b lk=%b", o.period, o.valid, o.early, o.late, o.locked, e.period, e.valid, e.early, e.late, e.locked); end end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL midreset extra events: got %0d, exp 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_boundary_collision();
        ev_t e, o;
        drive_tick(10, 1);
        drive_tick(12, 1);
        drive_tick(10, 1);
        drive_tick(10, 1);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL collision event: got none, exp p=%0d v=%b e=%b l=%b lk=%b", e.period, e.valid, e.early, e.late, e.locked); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL collision event: got p=%0d v=%b e=%b l=%b lk=%b, exp p=%0d v=%b e=%b l=%b lk=%b", o.period, o.valid, o.early, o.late, o.locked, e.period, e.valid, e.early, e.late, e.locked); end end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL collision extra events: got %0d, exp 0", obs_q.size()); obs_q.delete(); end
    endtask

    initial begin
        rst  = 1'b0;
        en   = 1'b0;
        tick = 1'b0;
        test_reset();
        test_nominal_lock();
        test_window_edges();
        test_timeout();
        test_stretched_tick();
        test_enable_drop();
        test_reset_mid();
        test_boundary_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
